vpu_seq: RTL
============

Name: vpu_seq

Overview:
Command-driven initiator for the combinational vpu_op ALU unit.
- Accepts one vector command (opcode, two source addresses, destination address, length) over a valid/ready handshake.
- Streams operand pairs from the vector scratchpad into vpu_op and writes each result back to the scratchpad.
- Sits between the VPU command queue and the vpu_op/scratchpad pair; vpu_op is instantiated alongside it, not inside it.

Parameters:
DATA_W, 32, element width (FP32)
OP_W, 4, opcode width
ADDR_W, 10, scratchpad word-address width
LEN_W, 11, element-count width (0..2^LEN_W-1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept a command
cmd_opcode  in  OP_W  0=ADD 1=SUB 2=RELU 3=MUL
cmd_src0  in  ADDR_W  base address of operand0 vector
cmd_src1  in  ADDR_W  base address of operand1 vector
cmd_dst  in  ADDR_W  base address of result vector
cmd_len  in  LEN_W  element count
busy  out  1  command in progress
done  out  1  one-cycle pulse when a command completes
err  out  1  valid with done; 1 = illegal opcode
rd0_en, rd0_addr  out  1, ADDR_W  operand0 read port; data returns the next cycle
rd0_data  in  DATA_W  operand0 read data
rd1_en, rd1_addr  out  1, ADDR_W  operand1 read port; same timing as port 0
rd1_data  in  DATA_W  operand1 read data
wr_en, wr_addr, wr_data  out  1, ADDR_W, DATA_W  result write port
vpu_start  out  1  drive to vpu_op start
vpu_opcode  out  OP_W  drive to vpu_op opcode
vpu_operand0, vpu_operand1  out  DATA_W  drive to vpu_op operands
vpu_result  in  DATA_W  vpu_op result (combinational in operands)

Behaviour:
- Clocking: single clock clk; rst is synchronous and active-high.
- Reset values: all outputs 0, except cmd_ready=1; state IDLE.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch all command fields and zero the issue and write counters.
  - len==0 or opcode>3 -> DONE; no read or write is ever issued; err=1 when opcode>3.
  - Otherwise -> RUN.
- RUN (cmd_ready=0, busy=1): each cycle assert rd0_en at src0+i; assert rd1_en at src1+i unless opcode==RELU. Increment i. After issuing element len-1 -> DRAIN.
- 3-stage pipeline; the memories never stall.
  - S0: issue read.
  - S1: read data valid; vpu_start=1, vpu_operand0=rd0_data, vpu_operand1=rd1_data (0 for RELU), vpu_opcode=latched opcode. vpu_result is registered at the end of S1.
  - S2: wr_en=1, wr_addr=dst+j, wr_data=registered result; j increments.
- Outside S1, vpu_start=0 and the vpu_operand*/vpu_opcode outputs are 0.
- DRAIN: no new reads; wait until write j==len-1 occurs -> DONE.
- DONE: done=1 for exactly one cycle, busy=0, err held valid that cycle -> IDLE. cmd_ready returns to 1 the cycle after DONE.
- Timing: command accepted at edge t gives reads at t+1..t+len, starts at t+2..t+len+1, writes at t+3..t+len+2, done at t+len+3.
- Address arithmetic is modulo 2^ADDR_W; base+i wraps silently.
- Overlap: overlapping src/dst ranges are allowed. A write never precedes the read of the same index; hazards between different indices are the caller's responsibility.
- cmd_valid while busy is ignored; the command is not lost, because the upstream holds it until cmd_ready.
- rst asserted mid-command: next cycle all enables are 0, state IDLE, the in-flight pipeline is discarded, and no further writes occur.
- err is cleared on the next accepted command.

Decomposition:
- vpu_pkg holds the opcode localparams (OP_ADD=0, OP_SUB=1, OP_RELU=2, OP_MUL=3), OP_W, and the state enum typedef; vpu_op and vpu_seq share it.
- No sub-module: the pipeline valid bits and two counters stay inline.

Test Plan:
1. ADD, len=3, src0={3F800000,40000000,BF800000}, src1={40000000,3F800000,3F800000} -> writes dst..dst+2 = {40400000,40400000,00000000}; done at t+6.
2. MUL, len=1, 40000000*40400000 -> wr_data=40C00000; SUB, 40400000-3F800000 -> 40000000.
3. RELU, len=2, src0={BF800000,40A00000} -> {00000000,40A00000}; rd1_en never asserted.
4. len=0, then opcode=7 with len=4 -> each gives done one cycle after accept, no rd/wr enables; err=0 then err=1.
5. dst=2^ADDR_W-1, len=2 -> writes to addresses 3FF then 000; cmd_valid held during busy is accepted only after done.
6. rst pulsed at the cycle of the second write of a len=5 command -> no wr_en afterwards, cmd_ready=1 the next cycle; a fresh command then completes normally.

Source files
------------

// File: rtl/vpu_pkg.sv
// Shared definitions for the vector unit: opcode encodings, opcode width,
// and the sequencer state type. Used by vpu_op and vpu_seq.
package vpu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_RELU = 4'd2;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } vpu_state_e;

    // Opcodes above MUL are rejected by the sequencer with err.
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op <= OP_MUL);
    endfunction

endpackage

// File: rtl/vpu_seq_if.sv
// Bundle of the sequencer's command, status, scratchpad and vpu_op signals.
// Command handshake: a command transfers on a rising edge where cmd_valid
// and cmd_ready are both 1; upstream holds cmd_* stable while cmd_valid=1
// and cmd_ready=0, and the sequencer never retracts cmd_ready without a
// transfer or a state change.
interface vpu_seq_if
    import vpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 11
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_opcode;
    logic [ADDR_W-1:0] cmd_src0;
    logic [ADDR_W-1:0] cmd_src1;
    logic [ADDR_W-1:0] cmd_dst;
    logic [LEN_W-1:0]  cmd_len;

    logic              busy;
    logic              done;
    logic              err;

    logic              rd0_en;
    logic [ADDR_W-1:0] rd0_addr;
    logic [DATA_W-1:0] rd0_data;
    logic              rd1_en;
    logic [ADDR_W-1:0] rd1_addr;
    logic [DATA_W-1:0] rd1_data;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              vpu_start;
    logic [OP_W-1:0]   vpu_opcode;
    logic [DATA_W-1:0] vpu_operand0;
    logic [DATA_W-1:0] vpu_operand1;
    logic [DATA_W-1:0] vpu_result;

    vpu_state_e        dbg_state;

    // Sequencer side.
    modport master (
        input  cmd_valid, cmd_opcode, cmd_src0, cmd_src1, cmd_dst, cmd_len,
        output cmd_ready, busy, done, err,
        output rd0_en, rd0_addr, rd1_en, rd1_addr,
        input  rd0_data, rd1_data,
        output wr_en, wr_addr, wr_data,
        output vpu_start, vpu_opcode, vpu_operand0, vpu_operand1,
        input  vpu_result,
        output dbg_state
    );

    // Environment side: command queue, scratchpad and vpu_op.
    modport slave (
        output cmd_valid, cmd_opcode, cmd_src0, cmd_src1, cmd_dst, cmd_len,
        input  cmd_ready, busy, done, err,
        input  rd0_en, rd0_addr, rd1_en, rd1_addr,
        output rd0_data, rd1_data,
        input  wr_en, wr_addr, wr_data,
        input  vpu_start, vpu_opcode, vpu_operand0, vpu_operand1,
        output vpu_result,
        input  dbg_state
    );

endinterface

// File: rtl/vpu_seq.sv
// Vector command sequencer: accepts one command, streams operand pairs from
// the scratchpad through vpu_op with a 3-stage read/compute/write pipeline,
// and writes each result back. Memories never stall, so the pipeline only
// carries two valid bits (S1, S2) alongside issue and write counters.
module vpu_seq
    import vpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 11
) (
    input logic       clk,
    input logic       rst,
    vpu_seq_if.master bus
);

    vpu_state_e        state_q,    state_d;
    logic [OP_W-1:0]   opcode_q,   opcode_d;
    logic [ADDR_W-1:0] src0_q,     src0_d;
    logic [ADDR_W-1:0] src1_q,     src1_d;
    logic [ADDR_W-1:0] dst_q,      dst_d;
    logic [LEN_W-1:0]  len_q,      len_d;
    logic [LEN_W-1:0]  issue_q,    issue_d;
    logic [LEN_W-1:0]  wr_cnt_q,   wr_cnt_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] result_q,   result_d;
    logic              err_q,      err_d;

    logic              is_relu;
    logic [LEN_W-1:0]  last_idx;

    assign is_relu  = (opcode_q == OP_RELU);
    assign last_idx = len_q - LEN_W'(1);

    // State, latched command, counters and pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            opcode_q   <= '0;
            src0_q     <= '0;
            src1_q     <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            issue_q    <= '0;
            wr_cnt_q   <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            src0_q     <= src0_d;
            src1_q     <= src1_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            issue_q    <= issue_d;
            wr_cnt_q   <= wr_cnt_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic, read issue, pipeline advance and write-back.
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        src0_d     = src0_q;
        src1_d     = src1_q;
        dst_d      = dst_q;
        len_d      = len_q;
        issue_d    = issue_q;
        wr_cnt_d   = wr_cnt_q;
        err_d      = err_q;
        s1_valid_d = 1'b0;
        s2_valid_d = s1_valid_q;
        result_d   = s1_valid_q ? bus.vpu_result : result_q;

        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.rd0_en    = 1'b0;
        bus.rd0_addr  = '0;
        bus.rd1_en    = 1'b0;
        bus.rd1_addr  = '0;

        // S2: write back the result registered at the end of S1.
        bus.wr_en   = s2_valid_q;
        bus.wr_addr = s2_valid_q ? (dst_q + ADDR_W'(wr_cnt_q)) : '0;
        bus.wr_data = s2_valid_q ? result_q : '0;
        if (s2_valid_q) begin
            wr_cnt_d = wr_cnt_q + LEN_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    opcode_d = bus.cmd_opcode;
                    src0_d   = bus.cmd_src0;
                    src1_d   = bus.cmd_src1;
                    dst_d    = bus.cmd_dst;
                    len_d    = bus.cmd_len;
                    issue_d  = '0;
                    wr_cnt_d = '0;
                    err_d    = !op_legal(bus.cmd_opcode);
                    // Empty or illegal commands finish without touching memory.
                    if ((bus.cmd_len == '0) || !op_legal(bus.cmd_opcode)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                bus.busy     = 1'b1;
                bus.rd0_en   = 1'b1;
                bus.rd0_addr = src0_q + ADDR_W'(issue_q);
                if (!is_relu) begin
                    bus.rd1_en   = 1'b1;
                    bus.rd1_addr = src1_q + ADDR_W'(issue_q);
                end
                s1_valid_d = 1'b1;
                issue_d    = issue_q + LEN_W'(1);
                if (issue_q == last_idx) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                bus.busy = 1'b1;
                if (s2_valid_q && (wr_cnt_q == last_idx)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // S1: present the returned read data to vpu_op; quiet otherwise.
    always_comb begin
        bus.vpu_start    = s1_valid_q;
        bus.vpu_opcode   = s1_valid_q ? opcode_q : '0;
        bus.vpu_operand0 = s1_valid_q ? bus.rd0_data : '0;
        bus.vpu_operand1 = (s1_valid_q && !is_relu) ? bus.rd1_data : '0;
    end

    assign bus.err       = err_q;
    assign bus.dbg_state = state_q;

endmodule
